// File: rtl/axi_pkg.sv
// Shared AXI4 constants, FSM state type and the AxSIZE helper for axi_burst_master.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5
  } state_t;

  // AxSIZE encodes log2 of the bytes per beat for a full-width bus.
  function automatic logic [2:0] size_code(input int bus_w);
    return 3'($clog2(bus_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 master issuing one INCR burst at a time, with pass-through data phases.
// Build option: define AXI_MASTER_STRB_EN to expose wr_strb; otherwise m_wstrb is all ones.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                Reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   wr_data,
`ifdef AXI_MASTER_STRB_EN
  input  logic [DATA_W/8-1:0] wr_strb,
`endif
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [LEN_W-1:0]    m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam logic [2:0] AXSIZE = size_code(DATA_W);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                awvalid_q, awvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rerr_q, rerr_d;

  logic                in_w, in_r, cnt_last;
  logic                w_beat, r_beat, r_beat_err, r_end;

  assign in_w     = (state_q == W);
  assign in_r     = (state_q == R);
  assign cnt_last = (cnt_q == len_q);
  assign w_beat   = in_w && wr_valid && m_wready;
  assign r_beat   = in_r && m_rvalid && rd_ready;
  // A beat is bad if its response is not OKAY or RLAST disagrees with our own count.
  assign r_beat_err = (m_rresp != RESP_OKAY) || (m_rlast != cnt_last);
  assign r_end      = r_beat && (cnt_last || m_rlast);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    arvalid_d = arvalid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rerr_d    = rerr_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          rerr_d = 1'b0;
          if (cmd_write) begin
            state_d   = AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = AR;
            arvalid_d = 1'b1;
          end
        end
      end
      AW: begin
        if (m_awready) begin
          awvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = W;
        end
      end
      W: begin
        if (w_beat) begin
          if (cnt_last) state_d = B;
          else          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      B: begin
        if (m_bvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (m_bresp != RESP_OKAY);
        end
      end
      AR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = R;
        end
      end
      R: begin
        if (r_beat) begin
          rerr_d = rerr_q | r_beat_err;
          if (r_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = rerr_q | r_beat_err;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rerr_q    <= rerr_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;

  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awlen   = len_q;
  assign m_awsize  = AXSIZE;
  assign m_awburst = BURST_INCR;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = AXSIZE;
  assign m_arburst = BURST_INCR;

  // Data phases are combinational so a beat costs no extra cycle.
  assign m_wvalid = in_w && wr_valid;
  assign wr_ready = in_w && m_wready;
  assign m_wdata  = in_w ? wr_data : '0;
  assign m_wlast  = in_w && cnt_last;
`ifdef AXI_MASTER_STRB_EN
  assign m_wstrb  = wr_strb;
`else
  assign m_wstrb  = '1;
`endif
  assign m_bready = (state_q == B);

  assign rd_valid = in_r && m_rvalid;
  assign m_rready = in_r && rd_ready;
  assign rd_data  = in_r ? m_rdata : '0;
  assign rd_last  = in_r && m_rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master with an in-bench AXI memory slave and random stimulus.
module tb_axi_burst_master;
  localparam int ADDR_W = 8, DATA_W = 32, LEN_W = 8, MEM_WORDS = 64;

  logic clk, Reset_n;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [DATA_W-1:0] wr_data;
`ifdef AXI_MASTER_STRB_EN
  logic [DATA_W/8-1:0] wr_strb;
`endif
  logic wr_valid, wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic rd_last, rd_valid, rd_ready, done, err;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [LEN_W-1:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [DATA_W/8-1:0] m_wstrb;

  axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
`ifdef AXI_MASTER_STRB_EN
    .wr_strb(wr_strb),
`endif
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len; } ax_t;
  typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;

  ax_t   exp_aw[$], exp_ar[$];
  beat_t exp_w[$], exp_rd[$];
  logic  exp_done[$];
  logic [DATA_W-1:0] wr_q[$];
  logic [DATA_W-1:0] wdata_buf[$];
  logic [DATA_W-1:0] ref_mem[MEM_WORDS];
  logic [DATA_W-1:0] slv_mem[MEM_WORDS];
  logic [1:0] inj_bresp;
  int inj_early_rlast, inj_rresp_at;
  int rd_mode;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int word_of(input logic [ADDR_W-1:0] addr, input int i);
    return ((int'(addr) >> 2) + i) % MEM_WORDS;
  endfunction

  // Memory slave: handshakes are observed on the falling edge, new drive values appear just after the rising edge.
  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic b_pend, r_act;
    int wbase, wcnt, rbase, rlen, rcnt;
    ax_t ax;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_arready = 0;
    m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    b_pend = 0; r_act = 0; wbase = 0; wcnt = 0; rbase = 0; rlen = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      if (!Reset_n) begin
        b_pend = 0; r_act = 0; wcnt = 0;
      end else begin
        aw_hs = m_awvalid && m_awready;
        w_hs  = m_wvalid && m_wready;
        b_hs  = m_bvalid && m_bready;
        ar_hs = m_arvalid && m_arready;
        r_hs  = m_rvalid && m_rready;
        if (aw_hs) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            ax = exp_aw.pop_front();
            chk("aw_addr", m_awaddr, ax.addr);
            chk("aw_len", m_awlen, ax.len);
            chk("aw_size", m_awsize, 3'd2);
            chk("aw_burst", m_awburst, 2'b01);
          end
          wbase = int'(m_awaddr) >> 2;
          wcnt = 0;
        end
        if (w_hs) begin
          slv_mem[(wbase + wcnt) % MEM_WORDS] = m_wdata;
          wcnt++;
          if (m_wlast) b_pend = 1;
        end
        if (ar_hs) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            ax = exp_ar.pop_front();
            chk("ar_addr", m_araddr, ax.addr);
            chk("ar_len", m_arlen, ax.len);
            chk("ar_size", m_arsize, 3'd2);
            chk("ar_burst", m_arburst, 2'b01);
          end
          rbase = int'(m_araddr) >> 2;
          rlen = int'(m_arlen);
          rcnt = 0;
          r_act = 1;
        end
        if (r_hs) begin
          rcnt++;
          if (m_rlast) r_act = 0;
        end
      end
      @(posedge clk);
      #1;
      if (!Reset_n) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0; m_rlast = 0;
      end else begin
        m_awready = 1'($urandom_range(1));
        m_wready  = ($urandom_range(3) != 0);
        m_arready = 1'($urandom_range(1));
        if (b_hs) m_bvalid = 0;
        if (b_pend && !m_bvalid && $urandom_range(1) == 1) begin
          m_bvalid = 1;
          m_bresp = inj_bresp;
          b_pend = 0;
        end
        if (r_hs || !m_rvalid) begin
          if (r_act && $urandom_range(3) != 0) begin
            m_rvalid = 1;
            m_rdata  = slv_mem[(rbase + rcnt) % MEM_WORDS];
            m_rlast  = (rcnt == rlen) || (rcnt == inj_early_rlast);
            m_rresp  = (rcnt == inj_rresp_at) ? axi_pkg::RESP_SLVERR : axi_pkg::RESP_OKAY;
          end else begin
            m_rvalid = 0;
            m_rlast = 0;
          end
        end
      end
    end
  end

  // Write-beat source: holds each beat until it is taken.
  initial begin : wr_src
    logic hs;
    wr_valid = 0; wr_data = 0;
`ifdef AXI_MASTER_STRB_EN
    wr_strb = '1;
`endif
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        wr_valid = 0;
      end
      if (!wr_valid && wr_q.size() > 0 && $urandom_range(3) != 0) begin
        wr_valid = 1;
        wr_data = wr_q[0];
      end
    end
  end

  initial begin : rd_sink
    rd_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0:       rd_ready = 1'($urandom_range(1));
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1;
      endcase
    end
  end

  initial begin : w_mon
    beat_t b;
    forever begin
      @(negedge clk);
      if (Reset_n && m_wvalid) chk("wr_ready_pass", wr_ready, m_wready);
      if (Reset_n && m_wvalid && m_wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          b = exp_w.pop_front();
          chk("w_data", m_wdata, b.data);
          chk("w_last", m_wlast, b.last);
          chk("w_strb", m_wstrb, 4'hF);
        end
      end
    end
  end

  initial begin : rd_mon
    beat_t b;
    forever begin
      @(negedge clk);
      if (Reset_n && m_rvalid) begin
        chk("m_rready_mirror", m_rready, rd_ready);
        chk("rd_valid_pass", rd_valid, 1);
      end
      if (Reset_n && rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          b = exp_rd.pop_front();
          chk("rd_data", rd_data, b.data);
          chk("rd_last", rd_last, b.last);
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (Reset_n && done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_err", err, exp_done.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    logic ok;
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({name, "_seen"}, ok, 1);
    if (ok) chk({name, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input int nbeats, input logic [1:0] bresp);
    ax_t ax;
    beat_t b;
    inj_bresp = bresp;
    ax.addr = addr; ax.len = LEN_W'(nbeats - 1);
    exp_aw.push_back(ax);
    for (int i = 0; i < nbeats; i++) begin
      ref_mem[word_of(addr, i)] = wdata_buf[i];
      b.data = wdata_buf[i]; b.last = (i == nbeats - 1);
      exp_w.push_back(b);
      wr_q.push_back(wdata_buf[i]);
    end
    exp_done.push_back(bresp != axi_pkg::RESP_OKAY);
    send_cmd(1'b1, addr, LEN_W'(nbeats - 1));
    wait_done("wr_done");
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input int nbeats, input int early_at,
                         input int rresp_at);
    ax_t ax;
    beat_t b;
    int nb;
    logic e;
    inj_early_rlast = early_at;
    inj_rresp_at = rresp_at;
    ax.addr = addr; ax.len = LEN_W'(nbeats - 1);
    exp_ar.push_back(ax);
    nb = (early_at >= 0) ? early_at + 1 : nbeats;
    for (int i = 0; i < nb; i++) begin
      b.data = ref_mem[word_of(addr, i)]; b.last = (i == nb - 1);
      exp_rd.push_back(b);
    end
    e = (early_at >= 0 && early_at != nbeats - 1) || (rresp_at >= 0 && rresp_at < nb);
    exp_done.push_back(e);
    send_cmd(1'b0, addr, LEN_W'(nbeats - 1));
    wait_done("rd_done");
  endtask

  task automatic fill_buf(input int n);
    wdata_buf.delete();
    for (int i = 0; i < n; i++) wdata_buf.push_back($urandom);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic ok;
    int nb, ea, ra;
    Reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    inj_bresp = 0; inj_early_rlast = -1; inj_rresp_at = -1; rd_mode = 2;
    for (int i = 0; i < MEM_WORDS; i++) begin ref_mem[i] = 0; slv_mem[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #2 Reset_n = 1;

    // Directed write/readback of three words at an unaligned start
    wdata_buf.delete();
    wdata_buf.push_back(32'h2C6DB86C);
    wdata_buf.push_back(32'h11223344);
    wdata_buf.push_back(32'hA5A5A5A5);
    rd_mode = 0;
    do_write(8'h03, 3, axi_pkg::RESP_OKAY);
    do_read(8'h03, 3, -1, -1);

    // 8-beat read with a sink that toggles its ready every cycle
    fill_buf(8);
    do_write(8'h40, 8, axi_pkg::RESP_OKAY);
    rd_mode = 1;
    do_read(8'h40, 8, -1, -1);
    rd_mode = 0;

    // Error responses: SLVERR on B, early RLAST, SLVERR on an R beat
    fill_buf(2);
    do_write(8'h20, 2, axi_pkg::RESP_SLVERR);
    do_read(8'h20, 2, -1, -1);
    fill_buf(4);
    do_write(8'h60, 4, axi_pkg::RESP_OKAY);
    do_read(8'h60, 4, 1, -1);
    do_read(8'h60, 4, -1, 2);

    // Randomised mix of commands
    for (int k = 0; k < 14; k++) begin
      nb = $urandom_range(16, 1);
      rd_mode = $urandom_range(2);
      if ($urandom_range(1) == 1) begin
        fill_buf(nb);
        do_write(8'($urandom), nb, ($urandom_range(3) == 0) ? axi_pkg::RESP_SLVERR : axi_pkg::RESP_OKAY);
      end else begin
        ea = (nb > 1 && $urandom_range(3) == 0) ? $urandom_range(nb - 2) : -1;
        ra = ($urandom_range(3) == 0) ? $urandom_range(nb - 1) : -1;
        do_read(8'($urandom), nb, ea, ra);
      end
    end

    // Longest burst: 256 beats
    rd_mode = 2;
    fill_buf(256);
    do_write(8'h00, 256, axi_pkg::RESP_OKAY);
    rd_mode = 0;
    do_read(8'h00, 256, -1, -1);

    // Reset in the middle of a write burst
    fill_buf(4);
    begin
      ax_t ax;
      beat_t b;
      ax.addr = 8'h00; ax.len = 8'd3;
      exp_aw.push_back(ax);
      for (int i = 0; i < 4; i++) begin
        b.data = wdata_buf[i]; b.last = (i == 3);
        exp_w.push_back(b);
        wr_q.push_back(wdata_buf[i]);
      end
      ref_mem[word_of(8'h00, 0)] = wdata_buf[0];
    end
    send_cmd(1'b1, 8'h00, 8'd3);
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (m_wvalid && m_wready) begin ok = 1; break; end
    end
    chk("mid_reset_first_beat", ok, 1);
    @(posedge clk);
    #2 Reset_n = 0;
    #1;
    chk("mrst_wvalid", m_wvalid, 0);
    chk("mrst_awvalid", m_awvalid, 0);
    chk("mrst_arvalid", m_arvalid, 0);
    chk("mrst_wr_ready", wr_ready, 0);
    chk("mrst_bready", m_bready, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_done", done, 0);
    wr_q.delete();
    exp_w.delete();
    wr_valid = 0;
    repeat (3) @(posedge clk);
    #2 Reset_n = 1;
    repeat (20) @(negedge clk);

    // Recovery after reset
    fill_buf(2);
    do_write(8'h80, 2, axi_pkg::RESP_OKAY);
    do_read(8'h80, 2, -1, -1);

    repeat (5) @(negedge clk);
    chk("left_exp_w", exp_w.size(), 0);
    chk("left_exp_rd", exp_rd.size(), 0);
    chk("left_exp_aw", exp_aw.size(), 0);
    chk("left_exp_ar", exp_ar.size(), 0);
    chk("left_exp_done", exp_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
